// File: rtl/memory_dumper.sv
// memory_dumper
//   Walks a RAM region after execution and streams each word out over a
//   valid/ready handshake, one read at a time (no read-ahead). The RAM read
//   port is driven only while a dump is in progress.
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous active-high reset
//   start          one-cycle pulse, begins a dump when idle
//   base_addr      first address to dump, sampled on start
//   word_count     number of words (0..2^ADDR_WIDTH), sampled on start
//   mem_addr       RAM read address (valid while mem_read)
//   mem_read       RAM read strobe
//   mem_read_data  RAM read data, valid READ_LATENCY cycles after mem_read
//   out_valid      out_data/out_addr hold a word
//   out_data       dumped word
//   out_addr       address of out_data
//   out_ready      consumer accepts a word when out_valid && out_ready
//   busy           high while a non-empty dump is in progress
//   done           one-cycle pulse when a dump completes
module memory_dumper #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   word_count,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_read,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_addr,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ISSUE  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_OUTPUT = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   // READ_LATENCY is at most 4, so three bits hold the countdown.
   localparam int              LAT_W    = 3;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY);
   localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

   logic [2:0]            state_q,     state_d;
   logic [ADDR_WIDTH-1:0] cur_addr_q,  cur_addr_d;
   logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
   logic [LAT_W-1:0]      lat_q,       lat_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
   logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;

   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      lat_d       = lat_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (word_count != '0) begin
                  cur_addr_d  = base_addr;
                  remaining_d = word_count;
                  state_d     = S_ISSUE;
               end else begin
                  // Empty dump: report completion without ever going busy.
                  state_d = S_FINISH;
               end
            end
         end

         S_ISSUE: begin
            lat_d   = LAT_LOAD;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            // lat_q reaches 1 in exactly the cycle the RAM presents the data
            // (READ_LATENCY cycles after the ISSUE cycle).
            if (lat_q == LAT_ONE) begin
               out_data_d  = mem_read_data;
               out_addr_d  = cur_addr_q;
               out_valid_d = 1'b1;
               lat_d       = '0;
               state_d     = S_OUTPUT;
            end else begin
               lat_d = lat_q - LAT_ONE;
            end
         end

         S_OUTPUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               // Address wraps naturally at 2^ADDR_WIDTH.
               cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
               remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
               if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end

         S_FINISH: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         lat_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         lat_q       <= lat_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
      end
   end

   // The read port is only driven during ISSUE; otherwise address is parked at 0.
   assign mem_read  = (state_q == S_ISSUE);
   assign mem_addr  = mem_read ? cur_addr_q : '0;
   assign busy      = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_OUTPUT);
   assign done      = (state_q == S_FINISH);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;

endmodule

// File: doc/memory_dumper.md
Name: memory_dumper

Overview:
- Read-side counterpart to the program loader: after execution, walks a RAM region and streams each word out over a valid/ready handshake.
- Lets the system read back results, such as data RAM contents, for checking or host upload.
- Sits between the system controller and the RAM read port.
- Owns the RAM read port only while busy.

Parameters:
ADDR_WIDTH, 16, RAM address width in bits
DATA_WIDTH, 16, RAM word width in bits
READ_LATENCY, 1, cycles from mem_read to valid mem_read_data (legal 1..4)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a dump when idle
base_addr  input  ADDR_WIDTH  first address, sampled on start
word_count  input  ADDR_WIDTH+1  number of words to dump (0..2^ADDR_WIDTH), sampled on start
mem_addr  output  ADDR_WIDTH  RAM read address
mem_read  output  1  RAM read strobe
mem_read_data  input  DATA_WIDTH  RAM read data, valid READ_LATENCY cycles after mem_read
out_valid  output  1  out_data/out_addr hold a word
out_data  output  DATA_WIDTH  dumped word
out_addr  output  ADDR_WIDTH  address of out_data
out_ready  input  1  consumer accepts word when out_valid && out_ready
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse when dump completes

Behaviour:
- Reset (synchronous, has priority over everything):
  - State goes to IDLE.
  - All outputs go to 0: mem_addr, mem_read, out_valid, out_data, out_addr, busy, done.
  - Internal address, remaining-count and latency counters are cleared.
  - Reset mid-dump abandons the dump; no done pulse is produced.
- States: IDLE, ISSUE, WAIT, OUTPUT, FINISH.
- IDLE:
  - start=1 and word_count!=0: latch base_addr into cur_addr and word_count into remaining, set busy=1, go to ISSUE.
  - start=1 and word_count==0: go to FINISH without asserting busy.
  - start while not in IDLE is ignored.
- ISSUE:
  - mem_read=1 and mem_addr=cur_addr for exactly one cycle.
  - Load the latency counter with READ_LATENCY, go to WAIT.
- WAIT:
  - Decrement the latency counter each cycle.
  - On the cycle mem_read_data is valid (READ_LATENCY cycles after ISSUE), capture out_data=mem_read_data and out_addr=cur_addr, set out_valid=1, go to OUTPUT.
- OUTPUT:
  - out_valid, out_data and out_addr are held stable until a handshake (out_valid && out_ready).
  - On handshake: out_valid=0, cur_addr=cur_addr+1 modulo 2^ADDR_WIDTH (wraps 0xFFFF->0x0000), remaining-=1.
  - After the handshake, if remaining becomes 0 go to FINISH, else go to ISSUE.
- FINISH:
  - done=1 for one cycle, busy=0, return to IDLE.
- Throughput: at most one word per (READ_LATENCY+2) cycles; no read-ahead.
- mem_read is never asserted outside ISSUE, and mem_read is never asserted while out_valid=1.
- Latency for READ_LATENCY=1, out_ready held high: start at cycle 0 -> mem_read at cycle 1 -> out_valid at cycle 3 (data captured at the end of cycle 2) -> handshake at cycle 3 -> next mem_read at cycle 4.
- word_count=2^ADDR_WIDTH dumps the whole memory once, starting at base_addr and wrapping.

Test Plan:
- RAM[0x10..0x13]=0xA001,0xA002,0xA003,0xA004; base=0x0010, count=4, out_ready=1 -> four handshakes with (addr,data) (0x10,A001)..(0x13,A004), one done pulse, busy low afterwards, exactly 4 mem_read pulses.
- Same dump with out_ready held low for 5 cycles on the second word -> out_data=0xA002 and out_addr=0x11 stable throughout the stall, no extra mem_read, full sequence still correct.
- base=0xFFFE, count=3, RAM[FFFE]=1, RAM[FFFF]=2, RAM[0000]=3 -> addrs FFFE, FFFF, 0000 with data 1, 2, 3.
- count=0 with start -> no mem_read, busy stays 0, done pulses one cycle after start.
- reset asserted while in WAIT during the second word -> next cycle all outputs 0, state IDLE, no done pulse; a new start then runs correctly.
- READ_LATENCY=3 build, count=2 -> out_valid first rises 5 cycles after start; start pulsed while busy is ignored (word count and addresses unchanged).
